// File: rtl/cby_bl_wl_loader.sv
// Bit-line / word-line configuration loader for a cby tile: assembles one BL frame per row from a
// byte stream, then strobes that row's WL. Define CFG_PARITY_EN to add per-beat even-parity checking.
module cby_bl_wl_loader #(
    parameter int unsigned BL_WIDTH        = 80,
    parameter int unsigned WL_WIDTH        = 80,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned WL_PULSE_CYCLES = 2
) (
    input  logic                            prog_clk,
    input  logic                            pReset,
    input  logic                            start,
    input  logic [$clog2(WL_WIDTH+1)-1:0]   num_rows,
    input  logic [DATA_WIDTH-1:0]           cfg_data,
    input  logic                            cfg_valid,
`ifdef CFG_PARITY_EN
    input  logic                            cfg_parity,
`endif
    output logic                            cfg_ready,
    input  logic                            cfg_last,
    output logic [0:BL_WIDTH-1]             bl,
    output logic [0:WL_WIDTH-1]             wl,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int unsigned BEATS   = BL_WIDTH / DATA_WIDTH;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PULSE_W = (WL_PULSE_CYCLES > 1) ? $clog2(WL_PULSE_CYCLES) : 1;
    localparam int unsigned ROW_W   = $clog2(WL_WIDTH + 1);

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(WL_PULSE_CYCLES - 1);
    localparam logic [ROW_W-1:0]   ROW_MAX    = ROW_W'(WL_WIDTH);

    typedef enum logic [2:0] {StIdle, StLoad, StPulse, StHold, StAbort} state_e;

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [PULSE_W-1:0]  pulse_q;
    logic [ROW_W-1:0]    row_q;
    logic [ROW_W-1:0]    rows_q;
    logic [ROW_W-1:0]    row_next;
    logic [0:BL_WIDTH-1] bl_loaded;
    logic [0:WL_WIDTH-1] wl_row;
    logic                parity_bad;

`ifdef CFG_PARITY_EN
    assign parity_bad = (^cfg_data) != cfg_parity;
`else
    assign parity_bad = 1'b0;
`endif

    assign row_next = row_q + 1'b1;

    // Beat k lands at bl[k*DATA_WIDTH + j] = cfg_data[j]; bit order is ascending on bl.
    always_comb begin
        bl_loaded = bl;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                for (int j = 0; j < DATA_WIDTH; j++) begin
                    bl_loaded[k*DATA_WIDTH + j] = cfg_data[j];
                end
            end
        end
    end

    always_comb begin
        wl_row = '0;
        for (int i = 0; i < WL_WIDTH; i++) begin
            wl_row[i] = (row_q == ROW_W'(i));
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            pulse_q   <= '0;
            row_q     <= '0;
            rows_q    <= '0;
            bl        <= '0;
            wl        <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_rows == '0 || num_rows > ROW_MAX) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            rows_q    <= num_rows;
                            row_q     <= '0;
                            beat_q    <= '0;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b1;
                            state_q   <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (cfg_valid) begin
                        if (parity_bad) begin
                            err       <= 1'b1;
                            cfg_ready <= 1'b0;
                            state_q   <= StAbort;
                        end else begin
                            bl <= bl_loaded;
                            if (beat_q == LAST_BEAT) begin
                                cfg_ready <= 1'b0;
                                if (cfg_last) begin
                                    wl      <= wl_row;
                                    pulse_q <= '0;
                                    state_q <= StPulse;
                                end else begin
                                    err     <= 1'b1;
                                    state_q <= StAbort;
                                end
                            end else if (cfg_last) begin
                                err       <= 1'b1;
                                cfg_ready <= 1'b0;
                                state_q   <= StAbort;
                            end else begin
                                beat_q <= beat_q + 1'b1;
                            end
                        end
                    end
                end
                StPulse: begin
                    if (pulse_q == PULSE_LAST) begin
                        wl      <= '0;
                        state_q <= StHold;
                    end else begin
                        pulse_q <= pulse_q + 1'b1;
                    end
                end
                StHold: begin
                    beat_q <= '0;
                    row_q  <= row_next;
                    if (row_next == rows_q) begin
                        done    <= 1'b1;
                        bl      <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cfg_ready <= 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StAbort: begin
                    // The faulting frame stays visible for this one cycle, then is wiped.
                    bl      <= '0;
                    wl      <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            assert (wl == '0 || (state_q == StPulse && $onehot(wl)))
                else $error("wl asserted outside PULSE or not one-hot");
        end
    end

endmodule

// File: tb/tb_cby_bl_wl_loader.sv
// Directed/randomized bench for cby_bl_wl_loader; expected BL frames and WL timing come from a
// row-level model of the loading protocol.
module tb_cby_bl_wl_loader;

    logic        prog_clk;
    logic        pReset;
    logic        start;
    logic [6:0]  num_rows;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_last;
`ifdef CFG_PARITY_EN
    logic        cfg_parity;
`endif
    logic        cfg_ready;
    logic [0:79] bl;
    logic [0:79] wl;
    logic        busy;
    logic        done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [0:79] exp_bl;
    logic [0:79] exp_wl;
    int          rise_cyc;

    cby_bl_wl_loader dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start),
        .num_rows  (num_rows),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
`ifdef CFG_PARITY_EN
        .cfg_parity(cfg_parity),
`endif
        .cfg_ready (cfg_ready),
        .cfg_last  (cfg_last),
        .bl        (bl),
        .wl        (wl),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp)
            else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_rows = 7'(n);
        tick();
        start    = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic bad_par);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
`ifdef CFG_PARITY_EN
        cfg_parity = (^d) ^ bad_par;
`else
        if (bad_par) $display("note: parity corruption requested without parity support");
`endif
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic model_beat(input int k, input logic [7:0] d);
        for (int j = 0; j < 8; j++) exp_bl[k*8 + j] = d[j];
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            tick();
            chk("stall_ready", 128'(cfg_ready), 128'(1));
            chk("stall_wl", 128'(wl), 128'(0));
        end
    endtask

    // One full row: BEATS beats (optionally stalled), WL pulse, hold, then row end.
    task automatic load_row(input int row, input bit last_row, input int max_stall,
                            input bit fixed_data);
        logic [7:0] d;
        for (int k = 0; k < 10; k++) begin
            stall($urandom_range(max_stall, 0));
            d = fixed_data ? 8'(k + 1) : 8'($urandom);
            send_beat(d, k == 9, 1'b0);
            model_beat(k, d);
            if (k < 9) chk("bl_beat", 128'(bl), 128'(exp_bl));
        end
        exp_wl = '0;
        exp_wl[row] = 1'b1;
        rise_cyc = cyc;
        chk("bl_row", 128'(bl), 128'(exp_bl));
        chk("wl_rise", 128'(wl), 128'(exp_wl));
        chk("ready_pulse", 128'(cfg_ready), 128'(0));
        tick();
        chk("wl_second", 128'(wl), 128'(exp_wl));
        chk("bl_pulse", 128'(bl), 128'(exp_bl));
        tick();
        chk("wl_fall", 128'(wl), 128'(0));
        chk("bl_hold", 128'(bl), 128'(exp_bl));
        chk("done_hold", 128'(done), 128'(0));
        tick();
        if (last_row) begin
            exp_bl = '0;
            chk("done_pulse", 128'(done), 128'(1));
            chk("bl_clear", 128'(bl), 128'(0));
            chk("busy_end", 128'(busy), 128'(0));
            tick();
            chk("done_once", 128'(done), 128'(0));
        end else begin
            chk("done_mid", 128'(done), 128'(0));
            chk("ready_next", 128'(cfg_ready), 128'(1));
            chk("busy_mid", 128'(busy), 128'(1));
        end
    endtask

    initial begin
        int s;
        int prev;
        int n;
        logic [7:0] d;

        pReset    = 1'b1;
        start     = 1'b0;
        num_rows  = '0;
        cfg_data  = '0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
`ifdef CFG_PARITY_EN
        cfg_parity = 1'b0;
`endif
        exp_bl = '0;
        exp_wl = '0;
        tick();
        tick();
        chk("rst_bl", 128'(bl), 128'(0));
        chk("rst_wl", 128'(wl), 128'(0));
        chk("rst_ready", 128'(cfg_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        pReset = 1'b0;
        tick();
        chk("idle_ready", 128'(cfg_ready), 128'(0));

        // Single row with fixed 0x01..0x0A payload.
        do_start(1);
        s = cyc;
        chk("start_busy", 128'(busy), 128'(1));
        chk("start_ready", 128'(cfg_ready), 128'(1));
        load_row(0, 1'b0 == 1'b1 ? 1'b0 : 1'b1, 0, 1'b1);
        chk("first_rise", 128'(rise_cyc - s), 128'(10));

        // Three back-to-back rows, no stalls: WL rises 13 cycles apart.
        do_start(3);
        s = cyc;
        load_row(0, 1'b0, 0, 1'b0);
        chk("rise0_lat", 128'(rise_cyc - s), 128'(10));
        prev = rise_cyc;
        load_row(1, 1'b0, 0, 1'b0);
        chk("rise1_gap", 128'(rise_cyc - prev), 128'(13));
        prev = rise_cyc;
        load_row(2, 1'b1, 0, 1'b0);
        chk("rise2_gap", 128'(rise_cyc - prev), 128'(13));

        // start while busy must not re-latch num_rows.
        do_start(2);
        start    = 1'b1;
        num_rows = 7'd1;
        cfg_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_start_ign", 128'(busy), 128'(1));
        load_row(0, 1'b0, 2, 1'b0);
        load_row(1, 1'b1, 2, 1'b0);

        // Random sessions with random stalls.
        for (int sess = 0; sess < 3; sess++) begin
            n = $urandom_range(4, 1);
            do_start(n);
            for (int r = 0; r < n; r++) load_row(r, r == n - 1, 3, 1'b0);
        end

        // Early cfg_last on beat 4: data of that beat still written, then abort.
        do_start(1);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            send_beat(d, k == 3, 1'b0);
            model_beat(k, d);
        end
        chk("early_err", 128'(err), 128'(1));
        chk("early_wl", 128'(wl), 128'(0));
        chk("early_bl", 128'(bl), 128'(exp_bl));
        chk("early_ready", 128'(cfg_ready), 128'(0));
        tick();
        exp_bl = '0;
        chk("early_busy", 128'(busy), 128'(0));
        chk("early_clr", 128'(bl), 128'(0));
        chk("early_sticky", 128'(err), 128'(1));
        chk("early_nodone", 128'(done), 128'(0));
        do_start(1);
        chk("err_cleared", 128'(err), 128'(0));
        load_row(0, 1'b1, 1, 1'b0);

        // Missing cfg_last on beat 10.
        do_start(1);
        for (int k = 0; k < 10; k++) send_beat(8'($urandom), 1'b0, 1'b0);
        chk("nolast_err", 128'(err), 128'(1));
        chk("nolast_wl", 128'(wl), 128'(0));
        tick();
        chk("nolast_busy", 128'(busy), 128'(0));
        chk("nolast_bl", 128'(bl), 128'(0));
        chk("nolast_wl2", 128'(wl), 128'(0));
        exp_bl = '0;

        // Illegal row counts.
        do_start(0);
        chk("zero_err", 128'(err), 128'(1));
        chk("zero_busy", 128'(busy), 128'(0));
        do_start(81);
        chk("big_err", 128'(err), 128'(1));
        chk("big_busy", 128'(busy), 128'(0));
        do_start(80);
        chk("max_ok", 128'(err), 128'(0));
        chk("max_busy", 128'(busy), 128'(1));
        pReset = 1'b1;
        #1;
        pReset = 1'b0;
        tick();

        // Asynchronous reset during PULSE of row 1.
        do_start(2);
        load_row(0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            send_beat(d, k == 9, 1'b0);
            model_beat(k, d);
        end
        exp_wl = '0;
        exp_wl[1] = 1'b1;
        chk("r1_wl", 128'(wl), 128'(exp_wl));
        #2;
        pReset = 1'b1;
        #1;
        chk("arst_wl", 128'(wl), 128'(0));
        chk("arst_bl", 128'(bl), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        tick();
        pReset = 1'b0;
        exp_bl = '0;
        tick();
        do_start(2);
        load_row(0, 1'b0, 1, 1'b0);
        load_row(1, 1'b1, 1, 1'b0);

`ifdef CFG_PARITY_EN
        // Bad parity on beat 3: slice 2 untouched, then abort clears bl.
        do_start(1);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send_beat(d, 1'b0, k == 2);
            if (k < 2) model_beat(k, d);
        end
        chk("par_err", 128'(err), 128'(1));
        chk("par_bl", 128'(bl), 128'(exp_bl));
        chk("par_wl", 128'(wl), 128'(0));
        tick();
        exp_bl = '0;
        chk("par_clr", 128'(bl), 128'(0));
        chk("par_busy", 128'(busy), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
